// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared types and constants for the instruction fetch slice.
//   fetch_state_t : fetch sequencer state (RUN / HALT / TRAP)
//   fetch_entry_t : one fetch buffer entry {pc, instr}. The pc field is
//                   32 bits wide so the type is independent of ADDR_WIDTH.
//                   Users zero-extend into it and truncate out of it.
//   PC_STEP       : byte increment between sequential fetches
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/instr_fetch_ctrl_buf.sv
// fetch_buf: small FIFO of fetch_entry_t sitting between fetch and decode.
//   clk, rst_n  : clock and asynchronous active-low reset
//   push, entry : write an entry at the tail
//   pop         : drop the head entry
//   flush       : empty the buffer; takes priority over push and pop
//   head        : current head entry, read straight from storage registers
//   full, empty : occupancy flags
//   count       : number of valid entries
// DEPTH must be a power of two so the pointers wrap without extra logic.
module fetch_buf
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             entry,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Cleared so the head outputs read as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer. Owns the PC, drives the combinational
// instruction memory, buffers {pc, word} pairs and hands them to decode over
// a valid/ready handshake. Handles execute redirects and halt requests.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_addr / imem_data      : instruction memory address (= pc) / word
//   redirect_valid/redirect_pc : PC change from execute; flushes the buffer
//   halt_req                   : level; stops new fetches while high
//   ins_valid/ins_ready        : decode handshake on the buffer head
//   ins_data/ins_pc            : head instruction word and its PC
//   trap_valid/trap_pc         : misaligned-redirect trap status
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN. When defined, a redirect
// with nonzero low bits enters TRAP until an aligned redirect arrives. When
// undefined, low bits are dropped and the trap outputs are constant zero.
module instr_fetch_ctrl
    import rv_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  ins_valid,
    input  logic                  ins_ready,
    output logic [31:0]           ins_data,
    output logic [ADDR_WIDTH-1:0] ins_pc,
    output logic                  trap_valid,
    output logic [ADDR_WIDTH-1:0] trap_pc
);

    fetch_state_t                 state;
    logic [ADDR_WIDTH-1:0]        pc;
    logic                         pop;
    logic                         fetch;
    logic                         full;
    logic                         empty;
    logic [$clog2(BUF_DEPTH):0]   count;
    fetch_entry_t                 head;
    fetch_entry_t                 new_entry;
    logic                         unused_bits;

    assign imem_addr = pc;
    assign ins_valid = !empty;
    assign ins_data  = head.instr;
    assign ins_pc    = head.pc[ADDR_WIDTH-1:0];

    // A handshake in a redirect cycle is voided by the flush, so no separate
    // pop masking is needed here.
    assign pop   = ins_valid && ins_ready;
    // Room exists when not full, or when the head leaves this same cycle.
    assign fetch = (state == RUN) && !redirect_valid && (!full || pop);

    assign new_entry = '{pc: 32'(pc), instr: imem_data};

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fetch),
        .entry (new_entry),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Bits that are intentionally not consumed (upper pc field, count, and
    // redirect low bits in builds that ignore them).
    assign unused_bits = ^{count, head.pc, redirect_pc[1:0]};

`ifdef IFETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pc         <= RESET_PC;
            trap_valid <= 1'b0;
            trap_pc    <= '0;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                state      <= TRAP;
                trap_valid <= 1'b1;
                trap_pc    <= redirect_pc;
            end else if (state == TRAP) begin
                state      <= RUN;
                trap_valid <= 1'b0;
                trap_pc    <= '0;
            end
        end else begin
            if (fetch) pc <= pc + ADDR_WIDTH'(PC_STEP);
            case (state)
                RUN:     if (halt_req)  state <= HALT;
                HALT:    if (!halt_req) state <= RUN;
                default: ;
            endcase
        end
    end
`else
    assign trap_valid = 1'b0;
    assign trap_pc    = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            if (fetch) pc <= pc + ADDR_WIDTH'(PC_STEP);
            case (state)
                RUN:     if (halt_req)  state <= HALT;
                HALT:    if (!halt_req) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios then randomized traffic,
// checked against a queue-level reference model of the fetch buffer.
module tb_instr_fetch_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt_req = 1'b0;
    logic          ins_valid;
    logic          ins_ready = 1'b0;
    logic [31:0]   ins_data;
    logic [AW-1:0] ins_pc;
    logic          trap_valid;
    logic [AW-1:0] trap_pc;

    logic [31:0] mem [64];
    assign imem_data = mem[imem_addr[7:2]];

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(8'h00), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  pc;
        logic [31:0] data;
    } ent_t;

    ent_t       mq[$];          // expected buffer contents, head at [0]
    logic [7:0] mpc;
    int         mstate;         // 0 run, 1 halt, 2 trap
    logic       mtrap;
    logic [7:0] mtrap_pc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        mpc      = 8'h00;
        mstate   = 0;
        mtrap    = 1'b0;
        mtrap_pc = 8'h00;
    endfunction

    initial begin
        bit pop;
        bit room;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                pop = (mq.size() > 0) && ins_ready;
                if (redirect_valid) begin
                    mq.delete();
                    mpc = {redirect_pc[7:2], 2'b00};
`ifdef IFETCH_MISALIGN_TRAP_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        mstate   = 2;
                        mtrap    = 1'b1;
                        mtrap_pc = redirect_pc;
                    end else if (mstate == 2) begin
                        mstate   = 0;
                        mtrap    = 1'b0;
                        mtrap_pc = 8'h00;
                    end
`endif
                end else begin
                    room = (mq.size() < DEPTH) || pop;
                    if (pop) void'(mq.pop_front());
                    if (mstate == 0 && room) begin
                        mq.push_back('{mpc, mem[mpc >> 2]});
                        mpc = mpc + 8'd4;
                    end
                    if (mstate == 0 && halt_req) mstate = 1;
                    else if (mstate == 1 && !halt_req) mstate = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("ins_valid", 32'(ins_valid), 32'(mq.size() != 0));
                if (ins_valid && mq.size() > 0) begin
                    check("ins_pc", 32'(ins_pc), 32'(mq[0].pc));
                    check("ins_data", ins_data, mq[0].data);
                end
                check("imem_addr", 32'(imem_addr), 32'(mpc));
                check("trap_valid", 32'(trap_valid), 32'(mtrap));
                check("trap_pc", 32'(trap_pc), 32'(mtrap_pc));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic rv, input logic [7:0] rpc, input logic h);
        @(negedge clk);
        ins_ready      = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = h;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
        check({tag, "_ins_data"},  ins_data,       32'd0);
        check({tag, "_ins_pc"},    32'(ins_pc),    32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_trap_valid"}, 32'(trap_valid), 32'd0);
        check({tag, "_trap_pc"},   32'(trap_pc),   32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'hFEDCB0B7;
        mem[1] = 32'h78900113;
        mem[4] = 32'h02101823;

        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");

        // release with decode ready: one instruction per cycle
        @(negedge clk);
        rst_n     = 1'b1;
        ins_ready = 1'b1;
        repeat (6) cyc(1, 0, 8'h00, 0);

        // decode stalls: buffer fills and pc holds
        repeat (4) cyc(0, 0, 8'h00, 0);
        repeat (4) cyc(1, 0, 8'h00, 0);

        // redirect to 0x10 with a full buffer and a same-cycle handshake
        repeat (3) cyc(0, 0, 8'h00, 0);
        cyc(1, 1, 8'h10, 0);
        repeat (5) cyc(1, 0, 8'h00, 0);

        // pc wrap from 0xF8
        cyc(1, 1, 8'hF8, 0);
        repeat (5) cyc(1, 0, 8'h00, 0);

        // halt for 3 cycles, then resume
        repeat (3) cyc(1, 0, 8'h00, 1);
        repeat (4) cyc(1, 0, 8'h00, 0);

        // misaligned redirect, later aligned redirect
        cyc(1, 1, 8'h12, 0);
        repeat (5) cyc(1, 0, 8'h00, 0);
        cyc(1, 1, 8'h20, 0);
        repeat (4) cyc(1, 0, 8'h00, 0);

        // asynchronous reset in the middle of traffic
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cyc(1, 0, 8'h00, 0);

        // randomized traffic
        begin
            logic h;
            logic [7:0] rpc;
            h = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 9) == 0) h = ~h;
                rpc = 8'($urandom);
                if ($urandom_range(0, 2) != 0) rpc[1:0] = 2'b00;
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc, h);
            end
        end
        repeat (3) cyc(1, 0, 8'h00, 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch sequencer for the RV32IM core. It owns the program counter and drives the byte address of the combinational instruction memory. It captures each returned word with its PC into a small fetch buffer and presents instructions to decode over a valid/ready handshake. It also handles control-flow redirects from execute and halt requests.

## Interface
Parameters:
- ADDR_WIDTH, 8: byte-address width of instruction memory; the PC is this wide.
- RESET_PC, 0: PC loaded on reset; must be word-aligned.
- BUF_DEPTH, 2: fetch buffer entries (power of two, ≥2).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- imem_addr  out  ADDR_WIDTH  byte address to instruction memory; always equals current PC.
- imem_data  in  32  instruction word; combinational from imem_addr, same cycle.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  ADDR_WIDTH  redirect target byte address.
- halt_req  in  1  level; while high, no new fetches are issued.
- ins_valid  out  1  buffer head holds a valid instruction.
- ins_ready  in  1  decode accepts the head this cycle.
- ins_data  out  32  head instruction word.
- ins_pc  out  ADDR_WIDTH  head instruction PC.
- trap_valid  out  1  misaligned redirect trap pending (tied 0 when feature is compiled out).
- trap_pc  out  ADDR_WIDTH  offending target (0 when feature is compiled out).

## Operation
- States: RUN, HALT, TRAP (TRAP exists only when the feature is compiled in).
- Fetch condition: state RUN, no redirect this cycle, and the buffer has room. Room means count < BUF_DEPTH, or the head is being popped this cycle.
- On a fetch: push {pc, imem_data}; pc ← pc + 4, truncated to ADDR_WIDTH (wraps 0xFC→0x00 at width 8).
- Pop when ins_valid && ins_ready. Push and pop in the same cycle is allowed at any occupancy, including full.
- Redirect (highest priority):
  - Flush all buffer entries, including the head.
  - A head handshake in the same cycle is void; decode must discard it.
  - pc ← redirect_pc with bits [1:0] cleared.
  - No push that cycle.
- RUN→HALT when halt_req=1 (and no redirect). HALT→RUN when halt_req=0.
- In HALT, the buffer still drains to decode and redirects still update pc and flush.
- Buffer order is strict FIFO; ins_data/ins_pc are registered buffer outputs, never combinational from imem_data.

## Timing
- Reset values: pc=RESET_PC, buffer empty, state RUN. Outputs: ins_valid=0, ins_data=0, ins_pc=0, trap_valid=0, trap_pc=0, imem_addr=RESET_PC.
- Fetch-to-decode latency is 1 cycle: the word fetched in cycle N is on ins_data in cycle N+1.
- With ins_ready held high, throughput is one instruction per cycle with no bubbles.
- Redirect in cycle N: ins_valid=0 in N+1; target instruction valid in N+2 at the earliest. imem_addr shows the target in N+1.
- ins_ready=0 with the buffer full: pc and imem_addr hold and no fetch occurs; resume in the cycle ins_ready returns.
- halt_req is sampled at the clock edge; the fetch in the cycle it first rises still occurs.
- rst_n asserted mid-operation: immediate asynchronous clear to the reset values; in-flight entries are lost.

## Configuration
- Macro: IFETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]≠0 enters TRAP and sets trap_valid=1, trap_pc=redirect_pc. The buffer is flushed and fetching stops. Only a later aligned redirect clears the trap (trap_valid=0, trap_pc=0) and returns to RUN.
- Not defined: low bits are silently cleared, there is no TRAP state, and trap outputs are constant 0.

## Structure
- Package rv_fetch_pkg holds:
  - fetch_state_t enum {RUN, HALT, TRAP};
  - fetch_entry_t packed struct {pc, instr};
  - PC_STEP=4 constant.
- Sub-module fetch_buf: parameterised FIFO of fetch_entry_t with push, pop, flush and full/empty/count. Flush has priority over push.
- The top level holds the pc register, the FSM and fetch-condition logic only.

## Test plan
Memory model: word 0=FEDCB0B7, word 1=78900113, word 4=02101823; ADDR_WIDTH=8.
- Reset release, ins_ready=1 → cycle 1: ins_valid=1, ins_pc=0x00, ins_data=FEDCB0B7; next cycle ins_pc=0x04, ins_data=78900113; one instruction per cycle thereafter.
- ins_ready=0 for 4 cycles from reset → buffer holds pc 0x00 and 0x04, imem_addr stalls at 0x08; on ins_ready=1, ins_pc sequence is 0x00, 0x04, 0x08 with no gaps or duplicates.
- Redirect to 0x10 while the buffer is full, with a same-cycle head handshake → ins_valid=0 next cycle; then ins_pc=0x10, ins_data=02101823; no stale entry appears.
- Run from pc 0xF8 → sequence 0xF8, 0xFC, 0x00 (wrap).
- halt_req=1 for 3 cycles with ins_ready=1 → buffer drains, then ins_valid=0 and imem_addr frozen; on release, fetch resumes at the held pc.
- Redirect to 0x12: with IFETCH_MISALIGN_TRAP_EN, trap_valid=1, trap_pc=0x12, ins_valid stays 0 until a redirect to 0x20; without the macro, next ins_pc=0x10.
